// File: rtl/stream_fifo_pipe_true_pkg.sv
// Shared helpers for stream_fifo_pipe_true.
// Holds width and pointer-increment helpers, so that every FIFO_DEPTH
// (including 1 and non-power-of-two values) is handled in one place.
package stream_fifo_pipe_true_pkg;

    // A pointer needs at least one bit, even when FIFO_DEPTH is 1.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit wrap from depth-1 back to 0. Power-of-two overflow is never
    // relied on, so non-power-of-two depths step through exactly depth slots.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_pipe_mem.sv
// Storage array for stream_fifo_pipe_true.
// Ports:
//   clk     - rising-edge clock for the write port
//   we_i    - write enable
//   waddr_i - write slot index
//   wdata_i - write payload
//   raddr_i - read slot index (asynchronous read)
//   rdata_o - contents of slot raddr_i
// The array has no reset. Only the owning FIFO's pointers and count are
// cleared, and they decide which slots hold valid data.
module stream_fifo_pipe_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo_pipe_true.sv
// Valid/ready stream FIFO with "pipe" behaviour. When the FIFO is full, it
// still accepts a write in any cycle where the reader pops.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous, active-high reset (clears pointers and count)
//   w_ready_o - write side ready (= !full || r_ready_i)
//   w_valid_i - write side valid
//   w_data_i  - write payload
//   r_valid_o - read side valid (count != 0, registered state only)
//   r_ready_i - read side ready
//   r_data_o  - head entry when r_valid_o, else zero
//   occ_o     - registered occupancy (only with STREAM_FIFO_PIPE_OCC_EN)
// Optional feature macro: STREAM_FIFO_PIPE_OCC_EN adds the occ_o port.
module stream_fifo_pipe_true
    import stream_fifo_pipe_true_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  w_ready_o,
    input  logic                  w_valid_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o
`ifdef STREAM_FIFO_PIPE_OCC_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occ_o
`endif
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign r_valid_o = (count_q != '0);
    // Full implies r_valid_o, so a ready reader always frees a slot this cycle.
    assign w_ready_o = !full || r_ready_i;
    assign push      = w_valid_i && w_ready_o;
    assign pop       = r_valid_o && r_ready_i;
    assign r_data_o  = r_valid_o ? head_data : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), FIFO_DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), FIFO_DEPTH));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full with a simultaneous push and pop, wr_ptr == rd_ptr. The
    // asynchronous read still shows the old head until the edge, and then
    // the new entry overwrites that freed slot.
    stream_fifo_pipe_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

`ifdef STREAM_FIFO_PIPE_OCC_EN
    assign occ_o = count_q;
`endif

endmodule
